// File: rtl/tdc_meas_sequencer_if.sv
// Bundle of requester, TDC and result signals around the measurement sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface tdc_meas_sequencer_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 32,
  parameter int REP_W = 4
);
  logic [1:0]             req;
  logic [WIN_W-1:0]       win_len0;
  logic [WIN_W-1:0]       win_len1;
  logic [REP_W-1:0]       reps;
  logic [1:0]             gnt;
  logic                   tdc_start;
  logic                   tdc_stop;
  logic [CNT_W-1:0]       tdc_count;
  logic                   busy;
  logic                   done;
  logic                   done_id;
  logic [CNT_W+REP_W-1:0] res_sum;
  logic [CNT_W-1:0]       res_min;
  logic [CNT_W-1:0]       res_max;

  modport slave (
    input  req, win_len0, win_len1, reps, tdc_count,
    output gnt, tdc_start, tdc_stop, busy, done, done_id, res_sum, res_min, res_max
  );

  modport master (
    output req, win_len0, win_len1, reps, tdc_count,
    input  gnt, tdc_start, tdc_stop, busy, done, done_id, res_sum, res_min, res_max
  );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// Round-robin TDC measurement sequencer: opens a gate window per repetition,
// samples the TDC count and returns sum/min/max to the granted requester.
module tdc_meas_sequencer #(
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 32,
  parameter int REP_W  = 4,
  parameter int SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  tdc_meas_sequencer_if.slave bus
);
  localparam int SUM_W = CNT_W + REP_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_GATE, S_STOP, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             winner_q, winner_d;
  logic             rr_q, rr_d;
  logic             done_id_q, done_id_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [SUM_W-1:0] sum_q, sum_d, res_sum_q, res_sum_d;
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] res_min_q, res_min_d, res_max_q, res_max_d;

  logic             pick;
  logic [WIN_W-1:0] pick_len;
  logic [SUM_W-1:0] new_sum;
  logic [CNT_W-1:0] new_min, new_max;
  logic             granted;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      winner_q  <= 1'b0;
      rr_q      <= 1'b0;
      done_id_q <= 1'b0;
      win_q     <= '0;
      cnt_q     <= '0;
      reps_q    <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      res_sum_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_q      <= rr_d;
      done_id_q <= done_id_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      reps_q    <= reps_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      res_sum_q <= res_sum_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_d      = rr_q;
    done_id_d = done_id_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    reps_d    = reps_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    res_sum_d = res_sum_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;

    // rr_q names the requester that wins a tie; it always points away from the last winner
    pick     = (bus.req == 2'b11) ? rr_q : bus.req[1];
    pick_len = pick ? bus.win_len1 : bus.win_len0;
    new_sum  = sum_q + SUM_W'(bus.tdc_count);
    new_min  = (bus.tdc_count < min_q) ? bus.tdc_count : min_q;
    new_max  = (bus.tdc_count > max_q) ? bus.tdc_count : max_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) state_d = S_ARB;
      end
      S_ARB: begin
        if (|bus.req) begin
          winner_d = pick;
          win_d    = (pick_len == '0) ? WIN_W'(1) : pick_len;
          reps_d   = (bus.reps == '0) ? REP_W'(1) : bus.reps;
          sum_d    = '0;
          min_d    = '1;
          max_d    = '0;
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = win_q - WIN_W'(1);
        state_d = S_GATE;
      end
      S_GATE: begin
        if (cnt_q == '0) begin
          cnt_d   = WIN_W'(1);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - WIN_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          cnt_d   = WIN_W'(SETTLE - 1);
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q - WIN_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - WIN_W'(1);
      end
      S_SAMPLE: begin
        sum_d  = new_sum;
        min_d  = new_min;
        max_d  = new_max;
        reps_d = reps_q - REP_W'(1);
        // Results are registered here so they are already valid in the done cycle
        if (reps_q == REP_W'(1)) begin
          res_sum_d = new_sum;
          res_min_d = new_min;
          res_max_d = new_max;
          done_id_d = winner_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_DONE: begin
        rr_d    = ~winner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign granted       = (state_q != S_IDLE) && (state_q != S_ARB);
  assign bus.gnt       = granted ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.tdc_start = (state_q == S_START);
  assign bus.tdc_stop  = (state_q == S_STOP);
  assign bus.done      = (state_q == S_DONE);
  assign bus.done_id   = done_id_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_min   = res_min_q;
  assign bus.res_max   = res_max_q;
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Self-checking bench for tdc_meas_sequencer: a timeline model predicts every
// output each cycle, and directed scenarios pin results with literal values.
module tb_tdc_meas_sequencer;
  localparam int WIN_W  = 16;
  localparam int CNT_W  = 32;
  localparam int REP_W  = 4;
  localparam int SETTLE = 2;
  localparam int SUM_W  = CNT_W + REP_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  tdc_meas_sequencer_if #(.WIN_W(WIN_W), .CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  tdc_meas_sequencer #(
    .WIN_W(WIN_W), .CNT_W(CNT_W), .REP_W(REP_W), .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: one granted sequence is described by its start cycle, window, reps and period
  longint           cyc = 0;
  longint           arbAt = -1, t0 = 0, doneAt = 0, busyTo = -1;
  longint           mW = 1, mR = 1, mP = 1;
  logic             mId = 1'b0, rr = 1'b0;
  bit               granted = 0, modelValid = 0, rstPrev = 1;
  logic [SUM_W-1:0] accSum = '0, expSum = '0;
  logic [CNT_W-1:0] accMin = '0, accMax = '0, expMin = '0, expMax = '0;
  logic             expId = 1'b0;

  int     startCnt = 0, stopCnt = 0, doneCnt = 0;
  longint lastStart = 0, stopGap = -1;
  logic   prevStop = 1'b0;

  logic [CNT_W-1:0] countPlan[$];
  logic             capId;
  logic [SUM_W-1:0] capSum;
  logic [CNT_W-1:0] capMin, capMax;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the timeline model
  initial begin
    longint phase;
    bit     inGrant, eStart, eStop, eDone, eBusy;
    logic [1:0] eGnt;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstPrev) begin
        arbAt = -1; granted = 0; busyTo = cyc - 1; rr = 1'b0;
        expSum = '0; expMin = '0; expMax = '0; expId = 1'b0;
        modelValid = 1;
      end
      if (modelValid) begin
        if (cyc == arbAt && bus.req != 2'b00) begin
          mId = (bus.req == 2'b11) ? rr : bus.req[1];
          mW  = longint'(mId ? bus.win_len1 : bus.win_len0);
          if (mW == 0) mW = 1;
          mR  = longint'(bus.reps);
          if (mR == 0) mR = 1;
          mP      = mW + 4 + SETTLE;
          t0      = cyc + 1;
          doneAt  = t0 + mR * mP;
          busyTo  = doneAt;
          granted = 1;
          accSum  = '0; accMin = '1; accMax = '0;
        end
        inGrant = granted && cyc >= t0 && cyc <= doneAt;
        phase   = (inGrant && cyc < doneAt) ? (cyc - t0) % mP : -1;
        eStart  = (phase == 0);
        eStop   = (phase == mW + 1) || (phase == mW + 2);
        eDone   = granted && cyc == doneAt;
        eBusy   = arbAt >= 0 && cyc >= arbAt && cyc <= busyTo;
        eGnt    = inGrant ? (mId ? 2'b10 : 2'b01) : 2'b00;
        if (phase == mW + 3 + SETTLE) begin
          accSum = accSum + SUM_W'(bus.tdc_count);
          if (bus.tdc_count < accMin) accMin = bus.tdc_count;
          if (bus.tdc_count > accMax) accMax = bus.tdc_count;
        end
        if (eDone) begin
          expSum = accSum; expMin = accMin; expMax = accMax; expId = mId;
          rr = ~mId;
        end
        checkOutput("tdc_start", 64'(bus.tdc_start), 64'(eStart));
        checkOutput("tdc_stop",  64'(bus.tdc_stop),  64'(eStop));
        checkOutput("busy",      64'(bus.busy),      64'(eBusy));
        checkOutput("gnt",       64'(bus.gnt),       64'(eGnt));
        checkOutput("done",      64'(bus.done),      64'(eDone));
        checkOutput("done_id",   64'(bus.done_id),   64'(expId));
        checkOutput("res_sum",   64'(bus.res_sum),   64'(expSum));
        checkOutput("res_min",   64'(bus.res_min),   64'(expMin));
        checkOutput("res_max",   64'(bus.res_max),   64'(expMax));
        if (rst_n == 1'b0 && cyc > busyTo && bus.req != 2'b00) begin
          arbAt  = cyc + 1;
          busyTo = cyc + 1;
        end
      end
      if (bus.tdc_start === 1'b1) begin startCnt++; lastStart = cyc; end
      if (bus.tdc_stop === 1'b1) begin
        stopCnt++;
        if (prevStop !== 1'b1) stopGap = cyc - lastStart;
      end
      if (bus.done === 1'b1) doneCnt++;
      prevStop = bus.tdc_stop;
      rstPrev  = (rst_n == 1'b1);
    end
  end

  // TDC stand-in: after each start pulse present the next planned count
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tdc_start === 1'b1 && countPlan.size() > 0) begin
        @(posedge clk);
        #2;
        bus.tdc_count = countPlan.pop_front();
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] req, input int w0, input int w1, input int reps);
    @(posedge clk);
    #1;
    bus.win_len0 = WIN_W'(w0);
    bus.win_len1 = WIN_W'(w1);
    bus.reps     = REP_W'(reps);
    bus.req      = req;
  endtask

  task automatic clearCounters();
    @(posedge clk);
    #1;
    startCnt = 0; stopCnt = 0; doneCnt = 0; stopGap = -1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", limit);
    end
    capId = bus.done_id; capSum = bus.res_sum; capMin = bus.res_min; capMax = bus.res_max;
  endtask

  task automatic waitStart(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.tdc_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    compared++;
    if (lat < 0) begin
      mismatched++;
      $display("[TB] FAIL start_timeout: got no tdc_start expected one within %0d cycles", limit);
    end
  endtask

  task automatic dropReq();
    @(posedge clk);
    #1;
    bus.req = 2'b00;
  endtask

  initial begin
    int lat;
    int doneBefore;
    bus.req = 2'b00; bus.win_len0 = '0; bus.win_len1 = '0; bus.reps = '0; bus.tdc_count = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    idleCycles(2);

    $display("[TB] single measurement, req0");
    countPlan = '{32'd7};
    clearCounters();
    applyStimulus(2'b01, 10, 0, 1);
    waitDone(200);
    dropReq();
    checkOutput("t1_done_id", 64'(capId), 64'd0);
    checkOutput("t1_sum", 64'(capSum), 64'd7);
    checkOutput("t1_min", 64'(capMin), 64'd7);
    checkOutput("t1_max", 64'(capMax), 64'd7);
    checkOutput("t1_model_sum", 64'(expSum), 64'd7);
    checkOutput("t1_starts", 64'(startCnt), 64'd1);
    checkOutput("t1_stop_cycles", 64'(stopCnt), 64'd2);
    checkOutput("t1_stop_gap", 64'(stopGap), 64'd11);
    idleCycles(3);

    $display("[TB] both requesters held from reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req = 2'b11; bus.win_len0 = WIN_W'(3); bus.win_len1 = WIN_W'(4); bus.reps = REP_W'(1);
    countPlan = '{32'd1, 32'd2, 32'd3};
    idleCycles(2);
    rst_n = 1'b0;
    waitDone(200);
    checkOutput("t2_first_id", 64'(capId), 64'd0);
    waitDone(200);
    checkOutput("t2_second_id", 64'(capId), 64'd1);
    checkOutput("t2_second_sum", 64'(capSum), 64'd2);
    waitDone(200);
    dropReq();
    checkOutput("t2_third_id", 64'(capId), 64'd0);
    idleCycles(3);

    $display("[TB] three repetitions");
    countPlan = '{32'd5, 32'd9, 32'd2};
    clearCounters();
    applyStimulus(2'b01, 4, 0, 3);
    waitDone(300);
    dropReq();
    checkOutput("t3_sum", 64'(capSum), 64'd16);
    checkOutput("t3_min", 64'(capMin), 64'd2);
    checkOutput("t3_max", 64'(capMax), 64'd9);
    checkOutput("t3_model_min", 64'(expMin), 64'd2);
    checkOutput("t3_starts", 64'(startCnt), 64'd3);
    idleCycles(3);

    $display("[TB] zero reps and zero window");
    countPlan = '{32'd11};
    clearCounters();
    applyStimulus(2'b01, 0, 0, 0);
    waitDone(200);
    dropReq();
    checkOutput("t4_starts", 64'(startCnt), 64'd1);
    checkOutput("t4_stop_gap", 64'(stopGap), 64'd2);
    checkOutput("t4_sum", 64'(capSum), 64'd11);
    idleCycles(3);

    $display("[TB] reset during gate");
    countPlan.delete();
    clearCounters();
    applyStimulus(2'b01, 20, 0, 2);
    waitStart(20, lat);
    doneBefore = doneCnt;
    idleCycles(5);
    rst_n = 1'b1;
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_start_after_rst", 64'(bus.tdc_start), 64'd0);
    checkOutput("t5_stop_after_rst", 64'(bus.tdc_stop), 64'd0);
    checkOutput("t5_gnt_after_rst", 64'(bus.gnt), 64'd0);
    checkOutput("t5_busy_after_rst", 64'(bus.busy), 64'd0);
    checkOutput("t5_sum_after_rst", 64'(bus.res_sum), 64'd0);
    idleCycles(30);
    checkOutput("t5_no_done", 64'(doneCnt), 64'(doneBefore));
    countPlan = '{32'd33};
    applyStimulus(2'b01, 2, 0, 1);
    waitStart(20, lat);
    checkOutput("t5_req_latency", 64'(lat), 64'd2);
    waitDone(200);
    dropReq();
    checkOutput("t5_fresh_sum", 64'(capSum), 64'd33);
    idleCycles(3);

    $display("[TB] config change and req drop mid-run");
    countPlan = '{32'd40};
    clearCounters();
    applyStimulus(2'b10, 0, 6, 1);
    waitStart(20, lat);
    checkOutput("t6_req_latency", 64'(lat), 64'd2);
    idleCycles(2);
    bus.win_len1 = WIN_W'(1);
    bus.req = 2'b00;
    waitDone(200);
    checkOutput("t6_done_id", 64'(capId), 64'd1);
    checkOutput("t6_sum", 64'(capSum), 64'd40);
    checkOutput("t6_stop_gap", 64'(stopGap), 64'd7);
    idleCycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
